// File: rtl/md_pkg.sv
// Shared encodings and configuration checks for the multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // True when the width/unroll pair can be built by the iterative datapath.
  function automatic bit md_unroll_ok(input int unsigned data_w, input int unsigned unroll);
    return (unroll == 1 || unroll == 2 || unroll == 4 || unroll == 8) &&
           (data_w >= 4) && (data_w % 2 == 0) && (data_w % unroll == 0);
  endfunction

endpackage

// File: rtl/md_if.sv
// Start/HI-LO access bus between the pipeline and the multiply/divide unit.
interface md_if #(parameter int unsigned DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              cancel;
  logic              hi_wen;
  logic              lo_wen;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output in_valid, in_op, in_a, in_b, cancel, hi_wen, lo_wen, wdata,
    input  in_ready, busy, done, hi, lo
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, cancel, hi_wen, lo_wen, wdata,
    output in_ready, busy, done, hi, lo
  );
endinterface

// File: rtl/md_step.sv
// One combinational iteration: shift-add multiply or restoring divide step.
module md_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W:0]   acc_i,
  input  logic [DATA_W-1:0] mq_i,
  input  logic [DATA_W:0]   opnd_i,
  output logic [DATA_W:0]   acc_o,
  output logic [DATA_W-1:0] mq_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   trial;
  logic [DATA_W+1:0] diff;

  // Multiply: add multiplicand on LSB then shift {acc,mq} right.
  // Divide: shift dividend bit into remainder, subtract if it fits.
  always_comb begin
    sum   = acc_i + (mq_i[0] ? opnd_i : '0);
    trial = {acc_i[DATA_W-1:0], mq_i[DATA_W-1]};
    diff  = {1'b0, trial} - {1'b0, opnd_i};
    acc_o = {1'b0, sum[DATA_W:1]};
    mq_o  = {sum[0], mq_i[DATA_W-1:1]};
    if (is_div) begin
      if (!diff[DATA_W+1]) begin
        acc_o = diff[DATA_W:0];
        mq_o  = {mq_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o = trial;
        mq_o  = {mq_i[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module md_unit import md_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned UNROLL = 1
) (
  input logic clk,
  input logic resetn,
  md_if.slave io
);

  localparam int unsigned N     = DATA_W / UNROLL;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * DATA_W;

  if (!md_unroll_ok(DATA_W, UNROLL)) begin : g_bad_cfg
    $error("md_unit: illegal DATA_W/UNROLL combination");
  end

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   acc_q, acc_d, opnd_q, opnd_d;
  logic [DATA_W-1:0] mq_q, mq_d, a_raw_q, a_raw_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic              busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic              signed_op, a_neg, b_neg;
  logic [DATA_W:0]   a_mag, b_mag;
  logic [PW:0]       prod_full;
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] res_hi, res_lo;

  logic [DATA_W:0]   acc_c [UNROLL+1];
  logic [DATA_W-1:0] mq_c  [UNROLL+1];

  assign acc_c[0] = acc_q;
  assign mq_c[0]  = mq_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    md_step #(.DATA_W(DATA_W)) u_step (
      .is_div (is_div_q),
      .acc_i  (acc_c[i]),
      .mq_i   (mq_c[i]),
      .opnd_i (opnd_q),
      .acc_o  (acc_c[i+1]),
      .mq_o   (mq_c[i+1])
    );
  end

  // Final result from the last chained step, with sign fix and divide-by-zero override.
  always_comb begin
    prod_full = {acc_c[UNROLL], mq_c[UNROLL]};
    prod      = PW'(neg_res_q ? -prod_full : prod_full);
    res_hi    = prod[PW-1:DATA_W];
    res_lo    = prod[DATA_W-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        res_lo = '1;
        res_hi = a_raw_q;
      end else begin
        res_lo = neg_res_q ? -mq_c[UNROLL] : mq_c[UNROLL];
        res_hi = DATA_W'(neg_rem_q ? -acc_c[UNROLL] : acc_c[UNROLL]);
      end
    end
  end

  // Next-state, operand capture, iteration and HI/LO write selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = io.hi_wen ? io.wdata : hi_q;
    lo_d      = io.lo_wen ? io.wdata : lo_q;
    signed_op = (io.in_op == MD_MULT) || (io.in_op == MD_DIV);
    a_neg     = signed_op & io.in_a[DATA_W-1];
    b_neg     = signed_op & io.in_b[DATA_W-1];
    a_mag     = a_neg ? -{io.in_a[DATA_W-1], io.in_a} : {1'b0, io.in_a};
    b_mag     = b_neg ? -{io.in_b[DATA_W-1], io.in_b} : {1'b0, io.in_b};

    unique case (state_q)
      IDLE: begin
        if (io.in_valid && !io.cancel) begin
          is_div_d  = io.in_op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (io.in_b == '0);
          a_raw_d   = io.in_a;
          acc_d     = '0;
          mq_d      = DATA_W'(io.in_op[1] ? a_mag : b_mag);
          opnd_d    = io.in_op[1] ? b_mag : a_mag;
          cnt_d     = CNT_W'(N);
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_d = acc_c[UNROLL];
        mq_d  = mq_c[UNROLL];
        cnt_d = cnt_q - CNT_W'(1);
        if (io.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == CALC);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // Architectural state and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Datapath working registers; contents are meaningless outside CALC.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign io.hi       = hi_q;
  assign io.lo       = lo_q;
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.in_ready = ready_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: UNROLL=1 and UNROLL=4 instances driven in lockstep.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  md_if #(.DATA_W(32)) b1 ();
  md_if #(.DATA_W(32)) b4 ();

  md_unit #(.DATA_W(32), .UNROLL(1)) u1 (.clk(clk), .resetn(resetn), .io(b1));
  md_unit #(.DATA_W(32), .UNROLL(4)) u4 (.clk(clk), .resetn(resetn), .io(b4));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    b1.in_valid = 0; b1.in_op = 0; b1.in_a = 0; b1.in_b = 0; b1.cancel = 0;
    b1.hi_wen = 0; b1.lo_wen = 0; b1.wdata = 0;
    b4.in_valid = 0; b4.in_op = 0; b4.in_a = 0; b4.in_b = 0; b4.cancel = 0;
    b4.hi_wen = 0; b4.lo_wen = 0; b4.wdata = 0;
  endtask

  // Start the same op on both units; optional lo_wen on unit 1 before edge number lo_wen_at+1.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int lo_wen_at,
                     output int cyc1, output int bsy1, output int cyc4, output int bsy4);
    int cyc;
    b1.in_valid = 1; b1.in_op = op; b1.in_a = a; b1.in_b = b;
    b4.in_valid = 1; b4.in_op = op; b4.in_a = a; b4.in_b = b;
    cyc = 0; cyc1 = 0; cyc4 = 0; bsy1 = 0; bsy4 = 0;
    while ((cyc1 == 0 || cyc4 == 0) && cyc < 60) begin
      b1.lo_wen = (cyc == lo_wen_at);
      b1.wdata  = 32'h0000AAAA;
      @(posedge clk); #1;
      b1.in_valid = 0; b4.in_valid = 0; b1.lo_wen = 0;
      cyc++;
      if (b1.busy) bsy1++;
      if (b4.busy) bsy4++;
      if (b1.done && cyc1 == 0) cyc1 = cyc;
      if (b4.done && cyc4 == 0) cyc4 = cyc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int c1, s1, c4, s4, ndone;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{MD_MULT,  32'hFFFFFFFF, 32'h0000000A, 32'hFFFFFFFF, 32'hFFFFFFF6};
    vecs[10] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", b1.hi, 0);
    check("rst_lo", b1.lo, 0);
    check("rst_busy", b1.busy, 0);
    check("rst_done", b1.done, 0);
    resetn = 1;
    @(posedge clk); #1;
    check("rst_ready", b1.in_ready, 1);
    check("rst_ready4", b4.in_ready, 1);

    // Result values, latency and busy length for both unroll settings.
    for (int i = 0; i < 11; i++) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, -1, c1, s1, c4, s4);
      check($sformatf("v%0d_hi_u1", i), b1.hi, vecs[i].hi);
      check($sformatf("v%0d_lo_u1", i), b1.lo, vecs[i].lo);
      check($sformatf("v%0d_hi_u4", i), b4.hi, vecs[i].hi);
      check($sformatf("v%0d_lo_u4", i), b4.lo, vecs[i].lo);
      check($sformatf("v%0d_lat_u1", i), c1, 33);
      check($sformatf("v%0d_lat_u4", i), c4, 9);
      check($sformatf("v%0d_busy_u1", i), s1, 32);
      check($sformatf("v%0d_busy_u4", i), s4, 8);
    end
    check("idle_done", b1.done, 0);
    check("idle_ready", b1.in_ready, 1);

    // Start request together with cancel in IDLE is ignored.
    b1.in_valid = 1; b1.cancel = 1; b1.in_op = MD_MULT; b1.in_a = 3; b1.in_b = 3;
    @(posedge clk); #1;
    b1.in_valid = 0; b1.cancel = 0;
    check("ign_busy", b1.busy, 0);
    check("ign_ready", b1.in_ready, 1);

    // Preload HI/LO, start MULT, cancel mid-flight.
    b1.hi_wen = 1; b1.lo_wen = 1; b1.wdata = 32'h1234;
    @(posedge clk); #1;
    b1.hi_wen = 0; b1.lo_wen = 0;
    check("mthi", b1.hi, 32'h1234);
    check("mtlo", b1.lo, 32'h1234);
    b1.in_valid = 1; b1.in_op = MD_MULT; b1.in_a = 5; b1.in_b = 6;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      b1.in_valid = 0;
    end
    check("pre_cancel_busy", b1.busy, 1);
    b1.cancel = 1;
    @(posedge clk); #1;
    b1.cancel = 0;
    check("cancel_ready", b1.in_ready, 1);
    check("cancel_busy", b1.busy, 0);
    check("cancel_done", b1.done, 0);
    check("cancel_hi", b1.hi, 32'h1234);
    check("cancel_lo", b1.lo, 32'h1234);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b1.done) ndone++;
    end
    check("cancel_no_done", ndone, 0);
    check("cancel_hi_hold", b1.hi, 32'h1234);

    // MTLO on the result edge loses to the result; MTLO in IDLE takes effect.
    run(MD_DIVU, 32'd100, 32'd7, 32, c1, s1, c4, s4);
    check("wen_race_lo", b1.lo, 32'd14);
    check("wen_race_hi", b1.hi, 32'd2);
    b1.lo_wen = 1; b1.wdata = 32'h0000AAAA;
    @(posedge clk); #1;
    b1.lo_wen = 0;
    check("mtlo_idle", b1.lo, 32'h0000AAAA);
    check("mtlo_idle_hi", b1.hi, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
